rule_cfg_loader: RTL and testbench
==================================

// Module: rule_cfg_loader
// PURPOSE
//  Control-plane writer feeding rule-programmed lookup tables of the parser. Accepts config words
//  on a narrow valid/ready stream and assembles each RULE_WIDTH-bit rule. Issues a one-cycle
//  one-hot write strobe plus rule data to the table's rule write port. Also supports rule clear.
// PARAMETERS
//  RULE_NUM    4    number of rule slots in target table (1..256)
//  RULE_WIDTH  113  rule word width = 1 valid + 2*TYPE_NUM*TYPE_WIDTH mask/value + key offsets
//  CFG_WIDTH   32   config stream word width (>=16)
//  BEATS       derived = ceil(RULE_WIDTH/CFG_WIDTH) (4 at defaults); beat counter width clog2(BEATS+1)
// PORTS
//  i_clk          in   1           clock
//  i_rst          in   1           async reset, active-high
//  i_cfg_valid    in   1           config word valid
//  i_cfg_data     in   CFG_WIDTH   config word (header or payload)
//  o_cfg_ready    out  1           loader can accept word; transfer = valid & ready
//  i_cfg_abort    in   1           discard partially assembled command
//  o_rule_wren    out  RULE_NUM    one-hot write strobe, 1 cycle
//  o_rule_wdata   out  RULE_WIDTH  rule data, valid while wren high, held until next commit
//  o_done         out  1           1-cycle pulse: command committed
//  o_err          out  1           1-cycle pulse: command rejected
//  o_busy         out  1           high in any state except IDLE
// BEHAVIOUR
//  Reset (async, i_rst=1): state IDLE; all outputs 0 except o_cfg_ready=0 during reset, 1 after.
//  Header word: [CFG_WIDTH-1 -: 8] opcode, [7:0] rule index. 0x01 WRITE, 0x02 CLEAR, other = bad op.
//  FSM states: IDLE, LOAD, DRAIN, COMMIT.
//  IDLE: ready=1. On header transfer:
//   - WRITE, index<RULE_NUM -> LOAD, beat cnt=0, latch index.
//   - WRITE, index>=RULE_NUM -> DRAIN (payload consumed, nothing written).
//   - CLEAR, index<RULE_NUM -> COMMIT with assembled data = 0 (clears rule valid bit).
//   - CLEAR bad index, or bad opcode -> o_err pulse next cycle, stay IDLE; no payload consumed.
//  LOAD: ready=1. Beat k lands in assembled bits [k*CFG_WIDTH +: CFG_WIDTH], LSB beat first.
//   Bits at or above RULE_WIDTH in the last beat are dropped. After beat BEATS-1 -> COMMIT.
//  DRAIN: ready=1. Accepts BEATS words, discards them. After last word: o_err pulse, -> IDLE.
//  COMMIT: ready=0 for exactly one cycle. o_rule_wren[idx]=1 and o_rule_wdata=assembled,
//   o_done=1. Then -> IDLE. All three are registered outputs.
//   Last-beat transfer at edge N -> wren/done high during cycle N+1.
//  Throughput: WRITE = 1 header + BEATS beats + 1 commit cycle; next header accepted cycle after COMMIT.
//  Gaps (valid low) in LOAD/DRAIN are legal; no timeout. Beat counter holds.
//  i_cfg_abort in LOAD/DRAIN: -> IDLE next cycle, assembled data discarded, no wren, o_err pulse.
//   Same-cycle word is not counted. Abort in IDLE/COMMIT: ignored; COMMIT still completes.
//  Reset mid-LOAD: no wren emitted; state IDLE; o_rule_wdata=0.
//  o_rule_wren never has more than one bit set; never set outside COMMIT.
// TESTING
//  1 WRITE idx2: hdr 0x01000002, beats 0x11111111,0x22222222,0x33333333,0x0001FFFF
//    -> wren=4'b0100 for 1 cycle, 1 cycle after last beat; wdata={17'h1FFFF,96'h333..222..111..}
//    (beat 3 = bits [112:96]); done=1.
//  2 CLEAR idx1: hdr 0x02000001 -> next cycle wren=4'b0010, wdata=0, done=1; ready=0 that cycle.
//  3 WRITE idx5 (RULE_NUM=4) + 4 beats -> all beats accepted, wren stays 0, err pulse after 4th beat.
//  4 Opcode 0x7F -> err pulse next cycle, busy stays 0, following valid header is processed normally.
//  5 WRITE idx0, 2 beats, then abort -> err pulse, no wren; next full WRITE idx0 writes only new data.
//  6 Random valid gaps across WRITE idx3; async reset asserted after beat 2 -> no wren, outputs 0.
//    After release a WRITE completes normally.

Source files
------------

// File: rtl/rule_cfg_loader.sv
// Rule configuration loader: assembles rule words from a narrow config
// stream and writes (or clears) one slot of a rule table per command.
module rule_cfg_loader #(
    parameter int RULE_NUM   = 4,
    parameter int RULE_WIDTH = 113,
    parameter int CFG_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cfg_valid,
    input  logic [CFG_WIDTH-1:0]  i_cfg_data,
    output logic                  o_cfg_ready,
    input  logic                  i_cfg_abort,
    output logic [RULE_NUM-1:0]   o_rule_wren,
    output logic [RULE_WIDTH-1:0] o_rule_wdata,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_busy
);

    localparam int BEATS = (RULE_WIDTH + CFG_WIDTH - 1) / CFG_WIDTH;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_CLEAR = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_COMMIT
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            idx_q, idx_d;
    logic [RULE_WIDTH-1:0] asm_q, asm_d;
    logic [RULE_NUM-1:0]   wren_q, wren_d;
    logic [RULE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;

    logic       xfer;
    logic [7:0] hdr_op;
    logic [7:0] hdr_idx;
    logic       hdr_idx_ok;

    assign xfer       = i_cfg_valid & ready_q;
    assign hdr_op     = i_cfg_data[CFG_WIDTH-1 -: 8];
    assign hdr_idx    = i_cfg_data[7:0];
    assign hdr_idx_ok = ({1'b0, hdr_idx} < 9'(RULE_NUM));

    // Decode a slot number into its one-hot write strobe.
    function automatic logic [RULE_NUM-1:0] one_hot(input logic [7:0] idx);
        logic [RULE_NUM-1:0] v;
        v = '0;
        for (int i = 0; i < RULE_NUM; i++) begin
            v[i] = (int'(idx) == i);
        end
        return v;
    endfunction

    // Next-state logic; commit/err outputs are computed on the edge that enters COMMIT or IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        wren_d  = '0;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (hdr_op == OP_WRITE) begin
                        cnt_d = '0;
                        asm_d = '0;
                        if (hdr_idx_ok) begin
                            idx_d   = hdr_idx;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else if (hdr_op == OP_CLEAR && hdr_idx_ok) begin
                        idx_d   = hdr_idx;
                        asm_d   = '0;
                        state_d = ST_COMMIT;
                        wren_d  = one_hot(hdr_idx);
                        wdata_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (i_cfg_abort) begin
                    asm_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    for (int b = 0; b < CFG_WIDTH; b++) begin
                        if (int'(cnt_q) * CFG_WIDTH + b < RULE_WIDTH) begin
                            asm_d[int'(cnt_q) * CFG_WIDTH + b] = i_cfg_data[b];
                        end
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_COMMIT;
                        wren_d  = one_hot(idx_q);
                        wdata_d = asm_d;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (i_cfg_abort) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    if (cnt_q == LAST_BEAT) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d != ST_COMMIT);
    end

    // State and output registers; reset clears everything including ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            wren_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign o_cfg_ready  = ready_q;
    assign o_rule_wren  = wren_q;
    assign o_rule_wdata = wdata_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rule_cfg_loader.sv
// Scoreboard bench for rule_cfg_loader: directed scenarios followed by random commands.
module tb_rule_cfg_loader;

    localparam int RULE_NUM   = 4;
    localparam int RULE_WIDTH = 113;
    localparam int CFG_WIDTH  = 32;
    localparam int BEATS      = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_valid;
    logic [CFG_WIDTH-1:0]  cfg_data;
    logic                  cfg_ready;
    logic                  cfg_abort;
    logic [RULE_NUM-1:0]   rule_wren;
    logic [RULE_WIDTH-1:0] rule_wdata;
    logic                  done;
    logic                  err;
    logic                  busy;

    rule_cfg_loader #(
        .RULE_NUM   (RULE_NUM),
        .RULE_WIDTH (RULE_WIDTH),
        .CFG_WIDTH  (CFG_WIDTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_valid  (cfg_valid),
        .i_cfg_data   (cfg_data),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_abort  (cfg_abort),
        .o_rule_wren  (rule_wren),
        .o_rule_wdata (rule_wdata),
        .o_done       (done),
        .o_err        (err),
        .o_busy       (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cycle_count = 0;

    // Count active edges so expected events can be tied to the edge that caused them.
    always @(posedge clk) cycle_count <= cycle_count + 1;

    typedef struct {
        bit                    is_err;
        int                    idx;
        logic [RULE_WIDTH-1:0] data;
        int                    due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: beats concatenated LSB-first, then cut to the rule width.
    function automatic logic [RULE_WIDTH-1:0] model_rule(input logic [CFG_WIDTH-1:0] beats[BEATS]);
        logic [BEATS*CFG_WIDTH-1:0] full;
        full = '0;
        for (int k = 0; k < BEATS; k++) begin
            full = full | ((BEATS*CFG_WIDTH)'(beats[k]) << (k * CFG_WIDTH));
        end
        return full[RULE_WIDTH-1:0];
    endfunction

    task automatic push_commit(input int idx, input logic [RULE_WIDTH-1:0] data);
        exp_t e;
        e.is_err = 1'b0;
        e.idx    = idx;
        e.data   = data;
        e.due    = cycle_count;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.idx    = 0;
        e.data   = '0;
        e.due    = cycle_count;
        exp_q.push_back(e);
    endtask

    // Monitor: every output event is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done || err || (rule_wren != '0)) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event", 128'({done, err, rule_wren}), 128'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("event_cycle", 128'(cycle_count), 128'(mon_e.due));
                    if (mon_e.is_err) begin
                        checkOutput("err_pulse", 128'(err), 128'(1));
                        checkOutput("err_no_done", 128'(done), 128'(0));
                        checkOutput("err_no_wren", 128'(rule_wren), 128'(0));
                        checkOutput("err_busy", 128'(busy), 128'(0));
                    end else begin
                        checkOutput("commit_wren", 128'(rule_wren), 128'(1) << mon_e.idx);
                        checkOutput("commit_wdata", 128'(rule_wdata), 128'(mon_e.data));
                        checkOutput("commit_done", 128'(done), 128'(1));
                        checkOutput("commit_no_err", 128'(err), 128'(0));
                        checkOutput("commit_ready", 128'(cfg_ready), 128'(0));
                        checkOutput("commit_busy", 128'(busy), 128'(1));
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due < cycle_count) begin
                checkOutput("missing_event", 128'(cycle_count), 128'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
        end
    end

    // Send one word after a random gap; returns once the handshake edge has passed.
    task automatic applyStimulus(input logic [CFG_WIDTH-1:0] word, input int max_gap);
        bit accepted;
        int waited;
        cfg_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b1;
        cfg_data  = word;
        accepted  = 1'b0;
        waited    = 0;
        while (!accepted && waited < 50) begin
            @(negedge clk);
            accepted = cfg_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!accepted) checkOutput("handshake_timeout", 128'(cfg_ready), 128'(1));
        cfg_valid = 1'b0;
        cfg_data  = $urandom;
    endtask

    function automatic logic [CFG_WIDTH-1:0] header(input logic [7:0] op, input int idx);
        logic [CFG_WIDTH-1:0] h;
        h = CFG_WIDTH'($urandom);
        h[CFG_WIDTH-1 -: 8] = op;
        h[7:0] = 8'(idx);
        return h;
    endfunction

    // WRITE command; abort_after < BEATS aborts after that many payload beats.
    task automatic send_write(input int idx, input logic [CFG_WIDTH-1:0] beats[BEATS],
                              input int abort_after, input int max_gap);
        applyStimulus(header(8'h01, idx), max_gap);
        for (int k = 0; k < BEATS; k++) begin
            if (k == abort_after) begin
                cfg_abort = 1'b1;
                @(posedge clk);
                #1;
                cfg_abort = 1'b0;
                push_err();
                return;
            end
            applyStimulus(beats[k], max_gap);
        end
        if (idx < RULE_NUM) push_commit(idx, model_rule(beats));
        else push_err();
    endtask

    // Header-only command: CLEAR or an unknown opcode.
    task automatic send_short(input logic [7:0] op, input int idx, input int max_gap);
        applyStimulus(header(op, idx), max_gap);
        if (op == 8'h02 && idx < RULE_NUM) push_commit(idx, '0);
        else push_err();
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_wren"}, 128'(rule_wren), 128'(0));
        checkOutput({tag, "_wdata"}, 128'(rule_wdata), 128'(0));
        checkOutput({tag, "_done"}, 128'(done), 128'(0));
        checkOutput({tag, "_err"}, 128'(err), 128'(0));
        checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
        checkOutput({tag, "_ready"}, 128'(cfg_ready), 128'(0));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, pending %0d expected events", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic [CFG_WIDTH-1:0] beats[BEATS];
        logic [7:0] op;
        int sel;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_abort = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", 128'(cfg_ready), 128'(1));
        checkOutput("idle_busy", 128'(busy), 128'(0));

        // Directed WRITE to slot 2.
        beats[0] = 32'h11111111;
        beats[1] = 32'h22222222;
        beats[2] = 32'h33333333;
        beats[3] = 32'h0001FFFF;
        send_write(2, beats, BEATS, 0);
        // CLEAR slot 1.
        send_short(8'h02, 1, 0);
        // WRITE to a slot that does not exist: payload drained, error reported.
        for (int k = 0; k < BEATS; k++) beats[k] = $urandom;
        send_write(5, beats, BEATS, 1);
        // Unknown opcode, then a normal command right behind it.
        send_short(8'h7F, 0, 0);
        send_short(8'h02, 3, 0);
        // Bad CLEAR index.
        send_short(8'h02, 4, 0);
        // Aborted WRITE to slot 0, then a full one.
        for (int k = 0; k < BEATS; k++) beats[k] = $urandom;
        send_write(0, beats, 2, 1);
        for (int k = 0; k < BEATS; k++) beats[k] = $urandom;
        send_write(0, beats, BEATS, 0);

        // Reset in the middle of a WRITE to slot 3.
        applyStimulus(header(8'h01, 3), 2);
        applyStimulus(32'hAAAA5555, 2);
        applyStimulus(32'h5A5A5A5A, 2);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midload_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_busy", 128'(busy), 128'(0));
        for (int k = 0; k < BEATS; k++) beats[k] = $urandom;
        send_write(3, beats, BEATS, 2);

        // Random commands.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                for (int k = 0; k < BEATS; k++) beats[k] = $urandom;
                send_write($urandom_range(0, 5), beats,
                           ($urandom_range(0, 4) == 0) ? $urandom_range(0, BEATS-1) : BEATS,
                           $urandom_range(0, 2));
            end else if (sel <= 7) begin
                send_short(8'h02, $urandom_range(0, 5), $urandom_range(0, 2));
            end else begin
                op = 8'($urandom);
                if (op == 8'h01 || op == 8'h02) op = 8'hFF;
                send_short(op, $urandom_range(0, 255), $urandom_range(0, 2));
            end
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
